// File: rtl/decode_pkg.sv
// Shared constants for the RV32I decode stage: opcodes, funct fields,
// ALU control encodings and the datapath width.
package decode_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } alu_ctrl_e;

endpackage

// File: rtl/decode_reg_file.sv
// Two-read/one-write register file with write-through reads; x0 reads as
// zero and is never written. All registers clear on asynchronous reset.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // A same-cycle writeback to the register being read wins over stored data.
  assign rd1 = (ra1 == 5'd0) ? '0 : (we && (wa == ra1)) ? wd : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : (we && (wa == ra2)) ? wd : regs[ra2];

endmodule

// File: rtl/decode_stage.sv
// ID stage of the 5-stage RV32I pipeline: decode, register read, BEQ/BNE
// resolution, load/branch hazard stalls and the ID/EX register.
// Build option BRANCH_FWD_EN forwards ALUOutM into the branch comparator.
module decode_stage #(
  parameter int XLEN  = decode_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCPD,
  input  logic            RegWriteW,
  input  logic [4:0]      WriteRegW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            RegWriteM,
  input  logic            MemtoRegM,
  input  logic [4:0]      WriteRegM,
  input  logic [XLEN-1:0] ALUOutM,
  output logic            PCSrcD,
  output logic [XLEN-1:0] PCBranchD,
  output logic            StallF,
  output logic            StallD,
  output logic            RegWriteE,
  output logic            MemtoRegE,
  output logic            MemWriteE,
  output logic            ALUSrcE,
  output logic [3:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmE,
  output logic [XLEN-1:0] PCPE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);
  import decode_pkg::*;

  function automatic logic signed [XLEN-1:0] sext13(input logic signed [12:0] v);
    return XLEN'(v);
  endfunction

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  assign opcode = InstrD[6:0];
  assign rd     = InstrD[11:7];
  assign funct3 = InstrD[14:12];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];
  assign funct7 = InstrD[31:25];

  logic signed [XLEN-1:0] imm_i, imm_s, imm_b;
  assign imm_i = sext13({InstrD[31], InstrD[31:20]});
  assign imm_s = sext13({InstrD[31], InstrD[31:25], InstrD[11:7]});
  assign imm_b = sext13({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0});

  // ---- stage p0: decode of InstrD ----
  logic                   regwrite_p0, memtoreg_p0, memwrite_p0, alusrc_p0;
  logic                   branch_p0, bne_p0, use_rs2_p0;
  alu_ctrl_e              aluctrl_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [XLEN-1:0]        rd1_p0, rd2_p0;

  always_comb begin
    regwrite_p0 = 1'b0;
    memtoreg_p0 = 1'b0;
    memwrite_p0 = 1'b0;
    alusrc_p0   = 1'b0;
    branch_p0   = 1'b0;
    bne_p0      = 1'b0;
    use_rs2_p0  = 1'b0;
    aluctrl_p0  = ALU_ADD;
    imm_p0      = '0;
    unique case (opcode)
      OP_R: begin
        regwrite_p0 = 1'b1;
        use_rs2_p0  = 1'b1;
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_SUB)       aluctrl_p0 = ALU_SUB;
            else if (funct7 != F7_BASE) regwrite_p0 = 1'b0;
          end
          F3_AND:  aluctrl_p0 = ALU_AND;
          F3_OR:   aluctrl_p0 = ALU_OR;
          F3_XOR:  aluctrl_p0 = ALU_XOR;
          F3_SLT:  aluctrl_p0 = ALU_SLT;
          default: regwrite_p0 = 1'b0;
        endcase
      end
      OP_I: begin
        regwrite_p0 = 1'b1;
        alusrc_p0   = 1'b1;
        imm_p0      = imm_i;
        case (funct3)
          F3_ADD:  aluctrl_p0 = ALU_ADD;
          F3_AND:  aluctrl_p0 = ALU_AND;
          F3_OR:   aluctrl_p0 = ALU_OR;
          F3_XOR:  aluctrl_p0 = ALU_XOR;
          F3_SLT:  aluctrl_p0 = ALU_SLT;
          default: regwrite_p0 = 1'b0;
        endcase
      end
      OP_LW: begin
        regwrite_p0 = (funct3 == F3_LW);
        memtoreg_p0 = (funct3 == F3_LW);
        alusrc_p0   = 1'b1;
        imm_p0      = imm_i;
      end
      OP_SW: begin
        memwrite_p0 = 1'b1;
        alusrc_p0   = 1'b1;
        use_rs2_p0  = 1'b1;
        imm_p0      = imm_s;
      end
      OP_BR: begin
        branch_p0  = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
        bne_p0     = (funct3 == F3_BNE);
        use_rs2_p0 = 1'b1;
        aluctrl_p0 = ALU_SUB;
        imm_p0     = imm_b;
      end
      default: ;
    endcase
  end

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .ra2   (rs2),
    .we    (RegWriteW),
    .wa    (WriteRegW),
    .wd    (ResultW),
    .rd1   (rd1_p0),
    .rd2   (rd2_p0)
  );

  logic [XLEN-1:0] br_a, br_b;
  logic            e_hit, m_hit, lwstall, branchstall, br_eq;

  assign e_hit = (RdE != 5'd0) && ((RdE == rs1) || (RdE == rs2));
  assign m_hit = (WriteRegM != 5'd0) && ((WriteRegM == rs1) || (WriteRegM == rs2));

`ifdef BRANCH_FWD_EN
  logic fwd_a, fwd_b;
  assign fwd_a = RegWriteM && !MemtoRegM && (WriteRegM != 5'd0) && (WriteRegM == rs1);
  assign fwd_b = RegWriteM && !MemtoRegM && (WriteRegM != 5'd0) && (WriteRegM == rs2);
  assign br_a  = fwd_a ? ALUOutM : rd1_p0;
  assign br_b  = fwd_b ? ALUOutM : rd2_p0;
  assign branchstall = branch_p0 && ((RegWriteE && e_hit) || (MemtoRegM && m_hit));
`else
  // Without M forwarding the branch waits until its producer reaches W.
  logic unused_aluoutm;
  assign unused_aluoutm = ^ALUOutM;
  assign br_a = rd1_p0;
  assign br_b = rd2_p0;
  assign branchstall = branch_p0 &&
                       ((RegWriteE && e_hit) || (MemtoRegM && m_hit) || (RegWriteM && m_hit));
`endif

  assign lwstall = MemtoRegE && (RdE != 5'd0) &&
                   ((RdE == rs1) || ((RdE == rs2) && use_rs2_p0));
  assign StallD  = lwstall || branchstall;
  assign StallF  = StallD;

  assign br_eq     = (br_a == br_b);
  assign PCSrcD    = branch_p0 && (bne_p0 ? !br_eq : br_eq) && !StallD;
  assign PCBranchD = PCPD - XLEN'(4) + $unsigned(imm_b);

  // ---- stage p1: ID/EX register ----
  logic            regwrite_p1, memtoreg_p1, memwrite_p1, alusrc_p1;
  logic [3:0]      aluctrl_p1;
  logic [XLEN-1:0] rd1_p1, rd2_p1, imm_p1, pcp_p1;
  logic [4:0]      rs1_p1, rs2_p1, rd_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {regwrite_p1, memtoreg_p1, memwrite_p1, alusrc_p1, aluctrl_p1} <= '0;
      {rd1_p1, rd2_p1, imm_p1, pcp_p1, rs1_p1, rs2_p1, rd_p1}        <= '0;
    end else if (StallD) begin
      {regwrite_p1, memtoreg_p1, memwrite_p1, alusrc_p1, aluctrl_p1} <= '0;
      {rd1_p1, rd2_p1, imm_p1, pcp_p1, rs1_p1, rs2_p1, rd_p1}        <= '0;
    end else begin
      regwrite_p1 <= regwrite_p0;
      memtoreg_p1 <= memtoreg_p0;
      memwrite_p1 <= memwrite_p0;
      alusrc_p1   <= alusrc_p0;
      aluctrl_p1  <= aluctrl_p0;
      rd1_p1      <= rd1_p0;
      rd2_p1      <= rd2_p0;
      imm_p1      <= $unsigned(imm_p0);
      pcp_p1      <= PCPD;
      rs1_p1      <= rs1;
      rs2_p1      <= rs2;
      rd_p1       <= rd;
    end
  end

  assign RegWriteE   = regwrite_p1;
  assign MemtoRegE   = memtoreg_p1;
  assign MemWriteE   = memwrite_p1;
  assign ALUSrcE     = alusrc_p1;
  assign ALUControlE = aluctrl_p1;
  assign RD1E        = rd1_p1;
  assign RD2E        = rd2_p1;
  assign ImmE        = imm_p1;
  assign PCPE        = pcp_p1;
  assign Rs1E        = rs1_p1;
  assign Rs2E        = rs2_p1;
  assign RdE         = rd_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a table of per-cycle vectors with expected E-stage
// contents queued at drive time and compared one clock later.
module tb_decode_stage;

  typedef struct packed {
    logic        rw, m2r, mw, asrc;
    logic [3:0]  alu;
    logic [31:0] rd1, rd2, imm, pcp;
    logic [4:0]  rs1, rs2, rd;
  } e_t;

  typedef struct packed {
    logic [31:0] instr, pcp;
    logic        rww;
    logic [4:0]  wrw;
    logic [31:0] resw;
    logic        rwm, m2rm;
    logic [4:0]  wrm;
    logic [31:0] alum;
  } in_t;

  typedef struct {
    in_t         in;
    logic        stall, pcsrc, chkbr;
    logic [31:0] pcbr;
    e_t          e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] InstrD, PCPD, ResultW, ALUOutM;
  logic        RegWriteW, RegWriteM, MemtoRegM;
  logic [4:0]  WriteRegW, WriteRegM;
  logic        PCSrcD, StallF, StallD;
  logic [31:0] PCBranchD;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmE, PCPE;
  logic [4:0]  Rs1E, Rs2E, RdE;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCPD(PCPD),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
    .ALUOutM(ALUOutM), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .StallF(StallF), .StallD(StallD), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE),
    .PCPE(PCPE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  e_t dut_e;
  assign dut_e = {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE,
                  RD1E, RD2E, ImmE, PCPE, Rs1E, Rs2E, RdE};

  int   checks = 0;
  int   errors = 0;
  e_t   sb[$];
  vec_t tbl[21];
  localparam e_t E0 = '0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [11:0] imm,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic in_t mki(input logic [31:0] instr, input logic [31:0] pcp,
                              input logic rww, input logic [4:0] wrw, input logic [31:0] resw);
    in_t i;
    i = '0;
    i.instr = instr; i.pcp = pcp; i.rww = rww; i.wrw = wrw; i.resw = resw;
    return i;
  endfunction

  function automatic e_t mke(input logic rw, input logic m2r, input logic mw, input logic asrc,
                             input logic [3:0] alu, input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] imm, input logic [31:0] pcp,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    return {rw, m2r, mw, asrc, alu, rd1, rd2, imm, pcp, rs1, rs2, rd};
  endfunction

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    InstrD = i.instr; PCPD = i.pcp;
    RegWriteW = i.rww; WriteRegW = i.wrw; ResultW = i.resw;
    RegWriteM = i.rwm; MemtoRegM = i.m2rm; WriteRegM = i.wrm; ALUOutM = i.alum;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    e_t exp;
    @(negedge clk);
    drive(v.in);
    #1;
    check({nm, "_StallF"}, 160'(StallF), 160'(v.stall));
    check({nm, "_StallD"}, 160'(StallD), 160'(v.stall));
    check({nm, "_PCSrcD"}, 160'(PCSrcD), 160'(v.pcsrc));
    if (v.chkbr) check({nm, "_PCBranchD"}, 160'(PCBranchD), 160'(v.pcbr));
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check({nm, "_E"}, 160'(dut_e), 160'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{mki(enc_i(7'b0010011, 12'd1, 5'd5, 3'b000, 5'd6), 32'h100, 1'b1, 5'd5, 32'h1234),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'h1234, 32'h0, 32'h1, 32'h100, 5'd5, 5'd1, 5'd6)};
    tbl[1]  = '{mki(enc_r(7'h00, 5'd1, 5'd5, 3'b000, 5'd9), 32'h104, 1'b1, 5'd1, 32'h3),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h1234, 32'h3, 32'h0, 32'h104, 5'd5, 5'd1, 5'd9)};
    tbl[2]  = '{mki(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd10), 32'h108, 1'b1, 5'd2, 32'h3),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h3, 32'h3, 32'h0, 32'h108, 5'd1, 5'd2, 5'd10)};
    tbl[3]  = '{mki(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000), 32'h104, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b1, 1'b1, 32'hF8,
                mke(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h3, 32'h3, 32'hFFFFFFF8, 32'h104, 5'd1, 5'd2, 5'd25)};
    tbl[4]  = '{mki(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000), 32'h104, 1'b1, 5'd2, 32'h4),
                1'b0, 1'b0, 1'b1, 32'hF8,
                mke(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h3, 32'h4, 32'hFFFFFFF8, 32'h104, 5'd1, 5'd2, 5'd25)};
    tbl[5]  = '{mki(enc_i(7'b0000011, 12'd0, 5'd1, 3'b010, 5'd7), 32'h110, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h3, 32'h0, 32'h0, 32'h110, 5'd1, 5'd0, 5'd7)};
    tbl[6]  = '{mki(enc_r(7'h00, 5'd1, 5'd7, 3'b000, 5'd8), 32'h114, 1'b0, 5'd0, 32'h0),
                1'b1, 1'b0, 1'b0, 32'h0, E0};
    tbl[7]  = '{mki(enc_r(7'h00, 5'd1, 5'd7, 3'b000, 5'd8), 32'h114, 1'b1, 5'd7, 32'h55),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h55, 32'h3, 32'h0, 32'h114, 5'd7, 5'd1, 5'd8)};
`ifdef BRANCH_FWD_EN
    tbl[8]  = '{mki(enc_b(13'd16, 5'd0, 5'd3, 3'b001), 32'h200, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b1, 1'b1, 32'h20C,
                mke(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0, 32'h0, 32'h10, 32'h200, 5'd3, 5'd0, 5'd16)};
`else
    tbl[8]  = '{mki(enc_b(13'd16, 5'd0, 5'd3, 3'b001), 32'h200, 1'b0, 5'd0, 32'h0),
                1'b1, 1'b0, 1'b1, 32'h20C, E0};
`endif
    tbl[8].in.rwm = 1'b1; tbl[8].in.m2rm = 1'b0; tbl[8].in.wrm = 5'd3; tbl[8].in.alum = 32'h9;
    tbl[9]  = '{mki(enc_b(13'd16, 5'd0, 5'd3, 3'b001), 32'h200, 1'b1, 5'd3, 32'h9),
                1'b0, 1'b1, 1'b1, 32'h20C,
                mke(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h9, 32'h0, 32'h10, 32'h200, 5'd3, 5'd0, 5'd16)};
    tbl[10] = '{mki(enc_i(7'b0010011, 12'd5, 5'd0, 3'b000, 5'd11), 32'h300, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 32'h1234, 32'h5, 32'h300, 5'd0, 5'd5, 5'd11)};
    tbl[11] = '{mki(enc_b(13'd8, 5'd0, 5'd11, 3'b000), 32'h304, 1'b0, 5'd0, 32'h0),
                1'b1, 1'b0, 1'b1, 32'h308, E0};
    tbl[12] = '{mki(32'h0, 32'h0, 1'b1, 5'd0, 32'hDEAD), 1'b0, 1'b0, 1'b0, 32'h0, E0};
    tbl[13] = '{mki(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 32'h400, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h3, 32'h4, 32'h0, 32'h400, 5'd1, 5'd2, 5'd0)};
    tbl[14] = '{mki(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd12), 32'h404, 1'b1, 5'd0, 32'hBEEF),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h404, 5'd0, 5'd0, 5'd12)};
    tbl[15] = '{mki(enc_s(12'hFFC, 5'd2, 5'd1), 32'h408, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 32'h3, 32'h4, 32'hFFFFFFFC, 32'h408, 5'd1, 5'd2, 5'd28)};
    tbl[16] = '{mki(enc_i(7'b0010011, 12'hFFF, 5'd1, 3'b100, 5'd13), 32'h40C, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 32'h3, 32'h0, 32'hFFFFFFFF, 32'h40C, 5'd1, 5'd31, 5'd13)};
    tbl[17] = '{mki(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd14), 32'h410, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 32'h3, 32'h4, 32'h0, 32'h410, 5'd1, 5'd2, 5'd14)};
    tbl[18] = '{mki(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd15), 32'h414, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'h3, 32'h4, 32'h0, 32'h414, 5'd1, 5'd2, 5'd15)};
    tbl[19] = '{mki(enc_i(7'b0010011, 12'h010, 5'd2, 3'b110, 5'd16), 32'h418, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'h4, 32'h0, 32'h10, 32'h418, 5'd2, 5'd16, 5'd16)};
    tbl[20] = '{mki(enc_i(7'b0010011, 12'd7, 5'd1, 3'b010, 5'd17), 32'h41C, 1'b0, 5'd0, 32'h0),
                1'b0, 1'b0, 1'b0, 32'h0,
                mke(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 32'h3, 32'h55, 32'h7, 32'h41C, 5'd1, 5'd7, 5'd17)};

    rst_n = 1'b0;
    drive('0);
    #12;
    check("reset_E", 160'(dut_e), 160'(E0));
    check("reset_StallD", 160'(StallD), 160'(1'b0));
    check("reset_PCSrcD", 160'(PCSrcD), 160'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) run_vec($sformatf("v%0d", i), tbl[i]);

    // Reset asserted while a load-use stall is active.
    run_vec("lw_x20", '{mki(enc_i(7'b0000011, 12'd0, 5'd2, 3'b010, 5'd20), 32'h500, 1'b0, 5'd0, 32'h0),
                        1'b0, 1'b0, 1'b0, 32'h0,
                        mke(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h4, 32'h0, 32'h0, 32'h500, 5'd2, 5'd0, 5'd20)});
    @(negedge clk);
    drive(mki(enc_r(7'h00, 5'd0, 5'd20, 3'b000, 5'd21), 32'h504, 1'b0, 5'd0, 32'h0));
    #1;
    check("midrst_stall_before", 160'(StallD), 160'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_E", 160'(dut_e), 160'(E0));
    check("midrst_stall_after", 160'(StallD), 160'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst_x5", '{mki(enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd22), 32'h600, 1'b0, 5'd0, 32'h0),
                             1'b0, 1'b0, 1'b0, 32'h0,
                             mke(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h600, 5'd5, 5'd0, 5'd22)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the IF/ID interface in the 5-stage RV32I pipeline.
- Takes InstrD/PCPD from the fetch stage, reads the register file and decodes controls, then loads the ID/EX register.
- Resolves BEQ/BNE in decode and returns PCSrcD/PCBranchD.
- Generates the StallF/StallD hazard controls that throttle fetch.

Parameters:
XLEN, 32, datapath width
NREGS, 32, register file depth; x0 hardwired to zero

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
InstrD  in  32  instruction held in IF/ID
PCPD  in  32  PC+4 of InstrD
RegWriteW  in  1  writeback enable
WriteRegW  in  5  writeback destination
ResultW  in  32  writeback data
RegWriteM  in  1  M-stage write enable
MemtoRegM  in  1  M-stage instruction is a load
WriteRegM  in  5  M-stage destination
ALUOutM  in  32  M-stage ALU result (branch forwarding)
PCSrcD  out  1  branch taken, redirect fetch
PCBranchD  out  32  branch target
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
RegWriteE, MemtoRegE, MemWriteE, ALUSrcE  out  1 each  ID/EX controls
ALUControlE  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT
RD1E, RD2E, ImmE, PCPE  out  32 each  ID/EX operands, sign-extended immediate, PC+4
Rs1E, Rs2E, RdE  out  5 each  ID/EX register indices

Behaviour:
- Reset (async, rst_n=0): all NREGS registers cleared; every ID/EX output = 0. PCSrcD, StallF and StallD are combinational and evaluate normally.
- Decoded subset:
  - R-type 0110011: ADD, SUB, AND, OR, XOR, SLT.
  - I-ALU 0010011: ADDI, ANDI, ORI, XORI, SLTI.
  - LW 0000011, SW 0100011, BEQ/BNE 1100011.
  - Any other opcode, including 0x00000000, decodes as a bubble: all write/memory enables 0.
- Immediates:
  - I-type: imm[11:0].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
  - All sign-extended to 32 bits.
- Register file:
  - Written on posedge clk when RegWriteW=1 and WriteRegW≠0.
  - Reads are combinational with write-through: if RegWriteW=1 and WriteRegW==rsX≠0, the read returns ResultW.
  - x0 always reads 0.
- Branch resolution, same cycle:
  - PCBranchD = (PCPD − 4) + ImmB, mod 2^32.
  - Equality is tested on the forwarded operands.
  - PCSrcD = branch & (eq for BEQ, ¬eq for BNE) & ¬StallD.
- Hazards:
  - lwstall = MemtoRegE & RdE≠0 & (RdE==rs1 | (RdE==rs2 & rs2 used)). rs2 is used by R-type, SW and branches.
  - branchstall (branch only): (RegWriteE & RdE≠0 & RdE matches rs1/rs2) | (MemtoRegM & WriteRegM≠0 & matches).
  - StallF = StallD = lwstall | branchstall.
- ID/EX register: loads on every posedge. On StallD=1 it loads a bubble: all controls 0, indices 0, data 0.
- Latency: one cycle from decode to E outputs.
- Boundaries:
  - rd=x0 writes are suppressed.
  - A simultaneous WB write and decode read of the same register yields the new value.
  - A stall coincident with PCSrcD forces PCSrcD=0.
  - Reset mid-stall clears the ID/EX register immediately.

Optional Feature:
- Macro: BRANCH_FWD_EN.
- Defined: branch operands forward ALUOutM when RegWriteM & ¬MemtoRegM & WriteRegM==rsX≠0. branchstall is exactly as above.
- Undefined: no M-stage forwarding. branchstall additionally asserts while RegWriteM & WriteRegM≠0 matches a branch source, so the branch waits until the producer reaches W.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants: OP_R, OP_I, OP_LW, OP_SW, OP_BR;
  - funct3/funct7 constants;
  - ALUControl encodings;
  - XLEN.
- One sub-module: reg_file (2 read ports, 1 write port, write-through, x0 zero, async reset clear).
- Decoder, immediate generation, hazard logic and the ID/EX register stay in decode_stage.

Test Plan:
- rst_n=0 mid-run → all E outputs 0 asynchronously; after release, reading x5 gives 0.
- Writeback x5=0x1234 while InstrD=ADDI x6,x5,1 → RD1E=0x1234, ImmE=1, ALUSrcE=1, RegWriteE=1, RdE=6.
- E holds LW x7; InstrD=ADD x8,x7,x1 → StallF=StallD=1 for one cycle; E gets a bubble; the ADD then issues with Rs1E=7.
- BEQ x1,x2,-8 with x1=x2=3, PCPD=0x104 → PCSrcD=1, PCBranchD=0xF8. Same with x2=4 → PCSrcD=0.
- BRANCH_FWD_EN: ADD x3 in M with ALUOutM=9, BNE x3,x0 → no stall, PCSrcD=1. Without the macro → one stall cycle, then resolves via write-through.
- InstrD=0x00000000, then an instruction writing x0 → bubble; x0 still reads 0.
